// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the write-back register file and the pipeline register blocks.
package wb_regfile_pkg;

  localparam int NR_OF_DATA_BITS = 32;
  localparam int NR_OF_ADDR_BITS = 5;
  localparam int REG_ZERO        = 0;

  // A pipeline slot only advances when both the global enable and the gating tick are high.
  function automatic logic eff_cycle(input logic clock_enable, input logic tick);
    return clock_enable & tick;
  endfunction

endpackage

// File: rtl/wb_regfile_read_port.sv
// One registered read port: zero-register / write-bypass / array select, plus the output registers.
module wb_regfile_read_port
  import wb_regfile_pkg::*;
#(
  parameter int NrOfDataBits = NR_OF_DATA_BITS,
  parameter int NrOfAddrBits = NR_OF_ADDR_BITS,
  parameter bit ZeroRegister = 1'b1
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    EffCycle,
  input  logic                    ReadEn,
  input  logic [NrOfAddrBits-1:0] ReadAddr,
  input  logic                    Commit,
  input  logic [NrOfAddrBits-1:0] WriteAddr,
  input  logic [NrOfDataBits-1:0] WriteData,
  input  logic [NrOfDataBits-1:0] ArrayData,
  output logic [NrOfDataBits-1:0] ReadData,
  output logic                    ReadValid
);

  logic [NrOfDataBits-1:0] sel_data;
  logic [NrOfDataBits-1:0] read_data_d, read_data_q;
  logic                    read_valid_d, read_valid_q;

  always_comb begin
    sel_data     = ArrayData;
    read_data_d  = read_data_q;
    read_valid_d = read_valid_q;
    // Write-first: a same-cycle commit to the addressed register wins over the stale array value.
    if (ZeroRegister && (ReadAddr == NrOfAddrBits'(REG_ZERO))) begin
      sel_data = '0;
    end else if (Commit && (WriteAddr == ReadAddr)) begin
      sel_data = WriteData;
    end
    if (EffCycle) begin
      read_valid_d = ReadEn;
      if (ReadEn) begin
        read_data_d = sel_data;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

  assign ReadData  = read_data_q;
  assign ReadValid = read_valid_q;

endmodule

// File: rtl/wb_register_file.sv
// Architectural register file: commits write-back results and serves two registered decode reads.
module wb_register_file
  import wb_regfile_pkg::*;
#(
  parameter int NrOfDataBits = NR_OF_DATA_BITS,
  parameter int NrOfAddrBits = NR_OF_ADDR_BITS,
  parameter bit ZeroRegister = 1'b1
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    ClockEnable,
  input  logic                    Tick,
  input  logic                    RegWrite,
  input  logic [NrOfAddrBits-1:0] WriteAddr,
  input  logic [NrOfDataBits-1:0] WriteData,
  input  logic                    ReadEnA,
  input  logic [NrOfAddrBits-1:0] ReadAddrA,
  input  logic                    ReadEnB,
  input  logic [NrOfAddrBits-1:0] ReadAddrB,
  output logic [NrOfDataBits-1:0] ReadDataA,
  output logic [NrOfDataBits-1:0] ReadDataB,
  output logic                    ReadValidA,
  output logic                    ReadValidB,
  output logic                    WriteAck
);

  localparam int Depth = 2 ** NrOfAddrBits;

  logic [NrOfDataBits-1:0] regs_q [Depth];
  logic                    eff;
  logic                    commit;
  logic                    write_ack_d, write_ack_q;

  assign eff    = eff_cycle(ClockEnable, Tick);
  // Writes to the hardwired zero register are dropped and never acknowledged.
  assign commit = RegWrite && !(ZeroRegister && (WriteAddr == NrOfAddrBits'(REG_ZERO)));

  always_comb begin
    write_ack_d = write_ack_q;
    if (eff) begin
      write_ack_d = commit;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
      write_ack_q <= 1'b0;
    end else begin
      if (eff && commit) begin
        regs_q[WriteAddr] <= WriteData;
      end
      write_ack_q <= write_ack_d;
    end
  end

  assign WriteAck = write_ack_q;

  wb_regfile_read_port #(
    .NrOfDataBits(NrOfDataBits),
    .NrOfAddrBits(NrOfAddrBits),
    .ZeroRegister(ZeroRegister)
  ) u_port_a (
    .Clock    (Clock),
    .Reset    (Reset),
    .EffCycle (eff),
    .ReadEn   (ReadEnA),
    .ReadAddr (ReadAddrA),
    .Commit   (commit),
    .WriteAddr(WriteAddr),
    .WriteData(WriteData),
    .ArrayData(regs_q[ReadAddrA]),
    .ReadData (ReadDataA),
    .ReadValid(ReadValidA)
  );

  wb_regfile_read_port #(
    .NrOfDataBits(NrOfDataBits),
    .NrOfAddrBits(NrOfAddrBits),
    .ZeroRegister(ZeroRegister)
  ) u_port_b (
    .Clock    (Clock),
    .Reset    (Reset),
    .EffCycle (eff),
    .ReadEn   (ReadEnB),
    .ReadAddr (ReadAddrB),
    .Commit   (commit),
    .WriteAddr(WriteAddr),
    .WriteData(WriteData),
    .ArrayData(regs_q[ReadAddrB]),
    .ReadData (ReadDataB),
    .ReadValid(ReadValidB)
  );

endmodule

// File: tb/tb_wb_register_file.sv
// Directed plus randomized bench for wb_register_file against a cycle-level behavioural model.
module tb_wb_register_file;

  logic        Clock;
  logic        Reset;
  logic        ClockEnable;
  logic        Tick;
  logic        RegWrite;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic        ReadEnA;
  logic [4:0]  ReadAddrA;
  logic        ReadEnB;
  logic [4:0]  ReadAddrB;
  logic [31:0] ReadDataA;
  logic [31:0] ReadDataB;
  logic        ReadValidA;
  logic        ReadValidB;
  logic        WriteAck;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_mem [32];
  logic [31:0] m_da, m_db;
  logic        m_va, m_vb, m_ack;

  wb_register_file #(
    .NrOfDataBits(32),
    .NrOfAddrBits(5),
    .ZeroRegister(1'b1)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .ClockEnable(ClockEnable),
    .Tick       (Tick),
    .RegWrite   (RegWrite),
    .WriteAddr  (WriteAddr),
    .WriteData  (WriteData),
    .ReadEnA    (ReadEnA),
    .ReadAddrA  (ReadAddrA),
    .ReadEnB    (ReadEnB),
    .ReadAddrB  (ReadAddrB),
    .ReadDataA  (ReadDataA),
    .ReadDataB  (ReadDataB),
    .ReadValidA (ReadValidA),
    .ReadValidB (ReadValidB),
    .WriteAck   (WriteAck)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // What a read of register a returns this cycle given the pending write (r0 always 0).
  function automatic logic [31:0] model_read(input logic [4:0] a, input logic wr_ok,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (wr_ok && wa == a) return wd;
    return m_mem[a];
  endfunction

  task automatic step(input string tag, input logic rst, input logic ce, input logic tk,
                      input logic rw, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ea, input logic [4:0] aa,
                      input logic eb, input logic [4:0] ab);
    logic wr_ok;
    Reset = rst; ClockEnable = ce; Tick = tk; RegWrite = rw;
    WriteAddr = wa; WriteData = wd;
    ReadEnA = ea; ReadAddrA = aa; ReadEnB = eb; ReadAddrB = ab;
    wr_ok = rw && (wa != 5'd0);
    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = 32'h0;
      m_da = 32'h0; m_db = 32'h0; m_va = 1'b0; m_vb = 1'b0; m_ack = 1'b0;
    end else if (ce && tk) begin
      m_va  = ea;
      m_vb  = eb;
      m_ack = wr_ok;
      if (ea) m_da = model_read(aa, wr_ok, wa, wd);
      if (eb) m_db = model_read(ab, wr_ok, wa, wd);
      if (wr_ok) m_mem[wa] = wd;
    end
    @(posedge Clock);
    #1;
    check({tag, ".dataA"},  ReadDataA,          m_da);
    check({tag, ".validA"}, {31'h0, ReadValidA}, {31'h0, m_va});
    check({tag, ".dataB"},  ReadDataB,          m_db);
    check({tag, ".validB"}, {31'h0, ReadValidB}, {31'h0, m_vb});
    check({tag, ".ack"},    {31'h0, WriteAck},   {31'h0, m_ack});
  endtask

  initial begin
    Reset = 1'b0; ClockEnable = 1'b0; Tick = 1'b0; RegWrite = 1'b0;
    WriteAddr = '0; WriteData = '0; ReadEnA = 1'b0; ReadAddrA = '0;
    ReadEnB = 1'b0; ReadAddrB = '0;
    foreach (m_mem[i]) m_mem[i] = 32'h0;
    m_da = '0; m_db = '0; m_va = 1'b0; m_vb = 1'b0; m_ack = 1'b0;
    @(negedge Clock);

    step("reset",      1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    // Reset then read r5
    step("wr_r5",      0, 1, 1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    step("rst_pulse",  1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step("rd_r5",      0, 1, 1, 0, 0, 0, 1, 5, 0, 0);
    check("rd_r5.zero", ReadDataA, 32'h0);
    // Bypass on both ports
    step("bypass",     0, 1, 1, 1, 7, 32'h12345678, 1, 7, 1, 7);
    check("bypass.lit", ReadDataB, 32'h12345678);
    // Zero register write and same-cycle read
    step("zero_wr",    0, 1, 1, 1, 0, 32'hFFFFFFFF, 1, 0, 1, 0);
    step("zero_rd",    0, 1, 1, 0, 0, 0, 1, 0, 1, 0);
    // Stall hold on r3
    step("wr_r3",      0, 1, 1, 1, 3, 32'hA5A5A5A5, 0, 0, 0, 0);
    step("rd_r3",      0, 1, 1, 0, 0, 0, 1, 3, 1, 3);
    for (int i = 0; i < 4; i++)
      step("stall", 0, 1, 0, 1, 3, $urandom, 1, 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    step("stall_ce",   0, 0, 1, 1, 3, 32'h0BADF00D, 1, 7, 0, 3);
    step("rd_r3_post", 0, 1, 1, 0, 0, 0, 1, 3, 1, 7);
    check("r3_kept",    ReadDataA, 32'hA5A5A5A5);
    // Reset during write and reset during a stall
    step("rst_wr",     1, 1, 1, 1, 9, 32'h55, 0, 0, 0, 0);
    step("rd_r9",      0, 1, 1, 0, 0, 0, 1, 9, 1, 9);
    step("rst_stall",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Independent ports
    step("wr_r1",      0, 1, 1, 1, 1, 32'h11, 0, 0, 1, 7);
    step("rd_r1",      0, 1, 1, 0, 0, 0, 1, 1, 0, 1);

    for (int n = 0; n < 400; n++) begin
      step("rand",
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 5) != 0,
           $urandom_range(0, 4) != 0,
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)),
           $urandom,
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
